ysyx_041461_scoreboard: RTL and testbench
=========================================

Name: ysyx_041461_scoreboard

Overview:
- In-order pending-write scoreboard; the producer-side counterpart to the pipeline conflict detector.
- Records the destination GPR and CSR of every instruction issued past decode.
- Retires entries in order at writeback and discards all entries on a trap flush.
- Answers combinational "is this source operand still pending?" queries, giving the ID stage a single stall signal with no per-stage compares.

Parameters:
- DEPTH, 4, max in-flight writing instructions; power of two, at least 2.
- REG_W, 5, GPR index width.
- CSR_W, 12, CSR address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- SB_issue_valid  in  1  instruction leaves ID this cycle
- SB_issue_rd_we  in  1  instruction writes a GPR
- SB_issue_rd  in  REG_W  destination GPR
- SB_issue_csr_we  in  1  instruction writes a CSR
- SB_issue_csr  in  CSR_W  destination CSR
- SB_issue_ready  out  1  space available (not full)
- SB_retire_valid  in  1  oldest instruction completes WB this cycle
- SB_flush  in  1  trap taken; discard all in-flight entries
- SB_rs1_read  in  1  query rs1
- SB_rs1  in  REG_W  source 1
- SB_rs2_read  in  1  query rs2
- SB_rs2  in  REG_W  source 2
- SB_csr_read  in  1  query CSR
- SB_csr  in  CSR_W  source CSR
- SB_conflict  out  1  a queried source has a pending write
- SB_count  out  $clog2(DEPTH)+1  number of valid entries
- SB_empty  out  1  count == 0

Behaviour:
- One clock, clk. Reset is synchronous, active-high on rst.
- Reset state: head = 0, tail = 0, count = 0, all entry fields 0.
- Reset output values: SB_issue_ready = 1, SB_conflict = 0, SB_count = 0, SB_empty = 1.
- Storage: circular FIFO of DEPTH entries {rd_we, rd, csr_we, csr}. head and tail are $clog2(DEPTH)-bit pointers that wrap modulo DEPTH.
- Issue: accepted when SB_issue_valid && SB_issue_ready && !SB_flush.
  - Writes the entry at tail; tail++, count++.
  - If SB_issue_rd == 0, rd_we is stored as 0.
  - Instructions with neither rd_we nor csr_we are still pushed, so retire stays one-per-instruction.
- SB_issue_ready = (count != DEPTH). It depends only on registered state; there is no same-cycle retire bypass.
- Issue while full: ignored, no state change. The ID stage must stall on !SB_issue_ready.
- Retire: when SB_retire_valid && count != 0 && !SB_flush, clear the head entry; head++, count--.
  - Retire while empty is ignored.
- Simultaneous issue and retire: both take effect; count is unchanged; pointers both advance.
- Flush: in the next cycle head = tail = 0 and count = 0, all entries are cleared, and same-cycle issue and retire are dropped. Flush has priority over everything except rst.
- Reset mid-operation: identical to flush, applied on the clock edge.
- Conflict check (combinational, zero latency, over registered entries only). SB_conflict = 1 if any valid entry satisfies one of:
  - (SB_rs1_read && SB_rs1 != 0 && rd_we && rd == SB_rs1)
  - (SB_rs2_read && SB_rs2 != 0 && rd_we && rd == SB_rs2)
  - (SB_csr_read && csr_we && csr == SB_csr)
- An entry issued this cycle is visible to queries from the next cycle onward.
- Validity of an entry is derived from head/count, not from a stored valid bit.

Optional Feature:
- Macro: YSYX_041461_SB_RETIRE_BYPASS_EN.
- Defined: the head entry is excluded from the conflict check in the cycle where SB_retire_valid && count != 0 && !SB_flush. This assumes the regfile/CSR file is write-through, which saves one stall cycle.
- Undefined: every valid entry, including one retiring this cycle, participates in the conflict check.

Decomposition:
- Shared package/defines file: DEPTH default, entry field widths, and an entry struct/bit-slice constants for {rd_we, rd, csr_we, csr}. These sit alongside the existing ysyx_041461 WB/TRAP defines.
- One sub-module is natural: ysyx_041461_sb_match. It is a purely combinational per-entry comparator producing a match bit from one entry plus the query ports; instantiate it DEPTH times and OR-reduce the outputs.
- The FIFO control stays in the top module.

Test Plan:
- Reset then idle -> SB_count = 0, SB_empty = 1, SB_issue_ready = 1, SB_conflict = 0 for any query.
- Issue rd = 5; next cycle query rs1 = 5 with rs1_read = 1 -> SB_conflict = 1. Query rs1 = 6 -> 0. Retire, then next cycle query rs1 = 5 -> 0.
- Issue rd = 0 with rd_we = 1, then query rs2 = 0 -> SB_conflict = 0. SB_count = 1.
- Issue 4 entries (rd = 1..4) -> SB_issue_ready = 0. A 5th issue is ignored: count stays 4 and tail does not move. Then issue and retire in the same cycle, 8 times -> pointers wrap and count stays 4 throughout.
- Issue csr = 0x300 with csr_we = 1, then query SB_csr = 0x300 with csr_read = 1 -> SB_conflict = 1. Assert SB_flush together with an issue of rd = 7 -> next cycle count = 0, and queries of rd 7 and csr 0x300 -> SB_conflict = 0.
- With one entry rd = 9: assert retire while querying rs1 = 9 -> SB_conflict = 0 with YSYX_041461_SB_RETIRE_BYPASS_EN defined, 1 without.

Source files
------------

// File: rtl/ysyx_041461_scoreboard_pkg.sv
// Shared definitions for the ysyx_041461 pending-write scoreboard: default sizing,
// the entry layout {rd_we, rd, csr_we, csr} and its bit-slice positions.
package ysyx_041461_scoreboard_pkg;

  localparam int unsigned SbDepth = 4;
  localparam int unsigned SbRegW  = 5;
  localparam int unsigned SbCsrW  = 12;

  typedef struct packed {
    logic              rd_we;
    logic [SbRegW-1:0] rd;
    logic              csr_we;
    logic [SbCsrW-1:0] csr;
  } sb_entry_t;

  localparam int unsigned SbEntryW   = $bits(sb_entry_t);
  localparam int unsigned SbCsrLsb   = 0;
  localparam int unsigned SbCsrWeBit = SbCsrW;
  localparam int unsigned SbRdLsb    = SbCsrW + 1;
  localparam int unsigned SbRdWeBit  = SbCsrW + SbRegW + 1;

endpackage

// File: rtl/ysyx_041461_scoreboard_if.sv
// Issue / retire / query bundle between the ID stage (master) and the scoreboard (slave).
interface ysyx_041461_scoreboard_if
  import ysyx_041461_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepth,
  parameter int unsigned REG_W = SbRegW,
  parameter int unsigned CSR_W = SbCsrW
);

  logic                     SB_issue_valid;
  logic                     SB_issue_rd_we;
  logic [REG_W-1:0]         SB_issue_rd;
  logic                     SB_issue_csr_we;
  logic [CSR_W-1:0]         SB_issue_csr;
  logic                     SB_issue_ready;
  logic                     SB_retire_valid;
  logic                     SB_flush;
  logic                     SB_rs1_read;
  logic [REG_W-1:0]         SB_rs1;
  logic                     SB_rs2_read;
  logic [REG_W-1:0]         SB_rs2;
  logic                     SB_csr_read;
  logic [CSR_W-1:0]         SB_csr;
  logic                     SB_conflict;
  logic [$clog2(DEPTH):0]   SB_count;
  logic                     SB_empty;

  modport master (
    output SB_issue_valid, SB_issue_rd_we, SB_issue_rd, SB_issue_csr_we, SB_issue_csr,
    output SB_retire_valid, SB_flush,
    output SB_rs1_read, SB_rs1, SB_rs2_read, SB_rs2, SB_csr_read, SB_csr,
    input  SB_issue_ready, SB_conflict, SB_count, SB_empty
  );

  modport slave (
    input  SB_issue_valid, SB_issue_rd_we, SB_issue_rd, SB_issue_csr_we, SB_issue_csr,
    input  SB_retire_valid, SB_flush,
    input  SB_rs1_read, SB_rs1, SB_rs2_read, SB_rs2, SB_csr_read, SB_csr,
    output SB_issue_ready, SB_conflict, SB_count, SB_empty
  );

endinterface

// File: rtl/ysyx_041461_sb_match.sv
// Per-entry comparator: flags a pending write by this entry to any queried source.
// x0 is never pending; CSR queries have no zero exemption.
module ysyx_041461_sb_match #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CSR_W = 12
) (
  input  logic             valid,
  input  logic             rd_we,
  input  logic [REG_W-1:0] rd,
  input  logic             csr_we,
  input  logic [CSR_W-1:0] csr,
  input  logic             rs1_read,
  input  logic [REG_W-1:0] rs1,
  input  logic             rs2_read,
  input  logic [REG_W-1:0] rs2,
  input  logic             csr_read,
  input  logic [CSR_W-1:0] csr_src,
  output logic             match
);

  logic hit_rs1;
  logic hit_rs2;
  logic hit_csr;

  // Source-by-source compare against this entry's destinations.
  always_comb begin
    hit_rs1 = rs1_read && (rs1 != '0) && rd_we && (rd == rs1);
    hit_rs2 = rs2_read && (rs2 != '0) && rd_we && (rd == rs2);
    hit_csr = csr_read && csr_we && (csr == csr_src);
    match   = valid && (hit_rs1 || hit_rs2 || hit_csr);
  end

endmodule

// File: rtl/ysyx_041461_scoreboard.sv
// In-order pending-write scoreboard. Entries are pushed at issue, popped at writeback
// and dropped wholesale on a trap flush; the ID stage gets one combinational stall bit.
// Optional macro YSYX_041461_SB_RETIRE_BYPASS_EN: hide the retiring head entry from
// queries (regfile/CSR file must be write-through).
module ysyx_041461_scoreboard
  import ysyx_041461_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepth,
  parameter int unsigned REG_W = SbRegW,
  parameter int unsigned CSR_W = SbCsrW
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_041461_scoreboard_if.slave sb
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  logic             rd_we_q  [DEPTH];
  logic [REG_W-1:0] rd_q     [DEPTH];
  logic             csr_we_q [DEPTH];
  logic [CSR_W-1:0] csr_q    [DEPTH];

  logic             issue_ready;
  logic             issue_fire;
  logic             retire_fire;
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_match;

  // Handshake qualification; ready looks at registered count only (no retire bypass).
  always_comb begin
    issue_ready = (count_q != CntW'(DEPTH));
    issue_fire  = sb.SB_issue_valid && issue_ready && !sb.SB_flush;
    retire_fire = sb.SB_retire_valid && (count_q != '0) && !sb.SB_flush;
  end

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (retire_fire) head_d = head_q + 1'b1;
    if (issue_fire)  tail_d = tail_q + 1'b1;
    unique case ({issue_fire, retire_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; flush behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || sb.SB_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_we_q[i]  <= 1'b0;
        rd_q[i]     <= '0;
        csr_we_q[i] <= 1'b0;
        csr_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Head and tail only coincide when empty or full, where one side is blocked.
      if (retire_fire) begin
        rd_we_q[head_q]  <= 1'b0;
        rd_q[head_q]     <= '0;
        csr_we_q[head_q] <= 1'b0;
        csr_q[head_q]    <= '0;
      end
      if (issue_fire) begin
        rd_we_q[tail_q]  <= sb.SB_issue_rd_we && (sb.SB_issue_rd != '0);
        rd_q[tail_q]     <= sb.SB_issue_rd;
        csr_we_q[tail_q] <= sb.SB_issue_csr_we;
        csr_q[tail_q]    <= sb.SB_issue_csr;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PtrW-1:0] offset;

    // Slot is live when its distance from head is below the occupancy.
    always_comb begin
      offset = PtrW'(g) - head_q;
`ifdef YSYX_041461_SB_RETIRE_BYPASS_EN
      ent_valid[g] = ({1'b0, offset} < count_q) && !(retire_fire && (head_q == PtrW'(g)));
`else
      ent_valid[g] = ({1'b0, offset} < count_q);
`endif
    end

    ysyx_041461_sb_match #(
      .REG_W (REG_W),
      .CSR_W (CSR_W)
    ) u_match (
      .valid    (ent_valid[g]),
      .rd_we    (rd_we_q[g]),
      .rd       (rd_q[g]),
      .csr_we   (csr_we_q[g]),
      .csr      (csr_q[g]),
      .rs1_read (sb.SB_rs1_read),
      .rs1      (sb.SB_rs1),
      .rs2_read (sb.SB_rs2_read),
      .rs2      (sb.SB_rs2),
      .csr_read (sb.SB_csr_read),
      .csr_src  (sb.SB_csr),
      .match    (ent_match[g])
    );
  end

  // Outputs.
  always_comb begin
    sb.SB_issue_ready = issue_ready;
    sb.SB_conflict    = |ent_match;
    sb.SB_count       = count_q;
    sb.SB_empty       = (count_q == '0);
  end

endmodule

// File: tb/tb_ysyx_041461_scoreboard.sv
// Directed bench for ysyx_041461_scoreboard with a queue-based reference model.
module tb_ysyx_041461_scoreboard;

  localparam int Depth = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  bit   chk_en;

  typedef struct {
    bit rd_we;
    int rd;
    bit csr_we;
    int csr;
  } ent_t;

  ent_t mq[$];

  ysyx_041461_scoreboard_if sb_if ();

  ysyx_041461_scoreboard u_dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: any queued write matching a live query is a conflict.
  function automatic int model_conflict();
    bit retire_now;
    retire_now = sb_if.SB_retire_valid && (mq.size() != 0) && !sb_if.SB_flush;
    for (int k = 0; k < mq.size(); k++) begin
`ifdef YSYX_041461_SB_RETIRE_BYPASS_EN
      if (k == 0 && retire_now) continue;
`endif
      if (sb_if.SB_rs1_read && sb_if.SB_rs1 != 0 && mq[k].rd_we && mq[k].rd == int'(sb_if.SB_rs1))
        return 1;
      if (sb_if.SB_rs2_read && sb_if.SB_rs2 != 0 && mq[k].rd_we && mq[k].rd == int'(sb_if.SB_rs2))
        return 1;
      if (sb_if.SB_csr_read && mq[k].csr_we && mq[k].csr == int'(sb_if.SB_csr))
        return 1;
    end
    return 0;
  endfunction

  // Model state update at the clock edge.
  always @(posedge clk) begin
    bit   can_issue;
    bit   do_ret;
    ent_t e;
    if (rst || sb_if.SB_flush) begin
      mq.delete();
    end else begin
      can_issue = sb_if.SB_issue_valid && (mq.size() != Depth);
      do_ret    = sb_if.SB_retire_valid && (mq.size() != 0);
      if (do_ret) void'(mq.pop_front());
      if (can_issue) begin
        e.rd_we  = sb_if.SB_issue_rd_we && (sb_if.SB_issue_rd != 0);
        e.rd     = int'(sb_if.SB_issue_rd);
        e.csr_we = sb_if.SB_issue_csr_we;
        e.csr    = int'(sb_if.SB_issue_csr);
        mq.push_back(e);
      end
    end
    chk_en <= 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", int'(sb_if.SB_issue_ready), int'(mq.size() != Depth));
      chk("count", int'(sb_if.SB_count), mq.size());
      chk("empty", int'(sb_if.SB_empty), int'(mq.size() == 0));
      chk("conflict", int'(sb_if.SB_conflict), model_conflict());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.SB_issue_valid  = 1'b0;
    sb_if.SB_issue_rd_we  = 1'b0;
    sb_if.SB_issue_rd     = '0;
    sb_if.SB_issue_csr_we = 1'b0;
    sb_if.SB_issue_csr    = '0;
    sb_if.SB_retire_valid = 1'b0;
    sb_if.SB_flush        = 1'b0;
    sb_if.SB_rs1_read     = 1'b0;
    sb_if.SB_rs1          = '0;
    sb_if.SB_rs2_read     = 1'b0;
    sb_if.SB_rs2          = '0;
    sb_if.SB_csr_read     = 1'b0;
    sb_if.SB_csr          = '0;
  endtask

  task automatic issue_rd(input int rd);
    sb_if.SB_issue_valid  = 1'b1;
    sb_if.SB_issue_rd_we  = 1'b1;
    sb_if.SB_issue_rd     = 5'(rd);
    sb_if.SB_issue_csr_we = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state with every query active.
    sb_if.SB_rs1_read = 1'b1; sb_if.SB_rs1 = 5'd5;
    sb_if.SB_rs2_read = 1'b1; sb_if.SB_rs2 = 5'd5;
    sb_if.SB_csr_read = 1'b1; sb_if.SB_csr = 12'h300;
    @(negedge clk);
    chk("lit_rst_count", int'(sb_if.SB_count), 0);
    chk("lit_rst_empty", int'(sb_if.SB_empty), 1);
    chk("lit_rst_ready", int'(sb_if.SB_issue_ready), 1);
    chk("lit_rst_conflict", int'(sb_if.SB_conflict), 0);

    // Single GPR write, hit / miss / retire.
    cyc();
    idle();
    issue_rd(5);
    cyc();
    idle();
    sb_if.SB_rs1_read = 1'b1; sb_if.SB_rs1 = 5'd5;
    @(negedge clk);
    chk("lit_rs1_5_hit", int'(sb_if.SB_conflict), 1);
    chk("lit_count_1", int'(sb_if.SB_count), 1);
    #1 sb_if.SB_rs1 = 5'd6;
    #1 chk("lit_rs1_6_miss", int'(sb_if.SB_conflict), 0);
    cyc();
    sb_if.SB_retire_valid = 1'b1;
    cyc();
    sb_if.SB_retire_valid = 1'b0;
    sb_if.SB_rs1 = 5'd5;
    @(negedge clk);
    chk("lit_rs1_5_retired", int'(sb_if.SB_conflict), 0);

    // Retire while empty is ignored.
    cyc();
    sb_if.SB_retire_valid = 1'b1;
    cyc();
    sb_if.SB_retire_valid = 1'b0;
    @(negedge clk);
    chk("lit_empty_retire_count", int'(sb_if.SB_count), 0);

    // x0 destination never conflicts but still occupies a slot.
    cyc();
    idle();
    issue_rd(0);
    cyc();
    idle();
    sb_if.SB_rs2_read = 1'b1; sb_if.SB_rs2 = 5'd0;
    @(negedge clk);
    chk("lit_x0_conflict", int'(sb_if.SB_conflict), 0);
    chk("lit_x0_count", int'(sb_if.SB_count), 1);
    cyc();
    sb_if.SB_retire_valid = 1'b1;
    cyc();
    idle();

    // Fill, then an ignored issue while full.
    for (int i = 1; i <= 4; i++) begin
      issue_rd(i);
      cyc();
    end
    idle();
    @(negedge clk);
    chk("lit_full_ready", int'(sb_if.SB_issue_ready), 0);
    chk("lit_full_count", int'(sb_if.SB_count), 4);
    cyc();
    issue_rd(20);
    cyc();
    idle();
    sb_if.SB_rs1_read = 1'b1; sb_if.SB_rs1 = 5'd20;
    @(negedge clk);
    chk("lit_full_drop_count", int'(sb_if.SB_count), 4);
    chk("lit_full_drop_rd20", int'(sb_if.SB_conflict), 0);
    #1 sb_if.SB_rs1 = 5'd3;
    #1 chk("lit_full_rd3", int'(sb_if.SB_conflict), 1);

    // Drop to 3 entries, then 8 simultaneous issue+retire to wrap the pointers.
    cyc();
    idle();
    sb_if.SB_retire_valid = 1'b1;
    cyc();
    for (int k = 0; k < 8; k++) begin
      issue_rd(10 + k);
      sb_if.SB_retire_valid = 1'b1;
      cyc();
      @(negedge clk);
      chk("lit_wrap_count", int'(sb_if.SB_count), 3);
      #1;
    end
    idle();
    sb_if.SB_rs1_read = 1'b1; sb_if.SB_rs1 = 5'd15;
    #1 chk("lit_wrap_rd15", int'(sb_if.SB_conflict), 1);
    sb_if.SB_rs1 = 5'd14;
    #1 chk("lit_wrap_rd14", int'(sb_if.SB_conflict), 0);
    sb_if.SB_rs1_read = 1'b0;
    sb_if.SB_rs2_read = 1'b1; sb_if.SB_rs2 = 5'd17;
    #1 chk("lit_wrap_rs2_17", int'(sb_if.SB_conflict), 1);

    // Flush to clear.
    cyc();
    idle();
    sb_if.SB_flush = 1'b1;
    cyc();
    sb_if.SB_flush = 1'b0;
    @(negedge clk);
    chk("lit_flush_count", int'(sb_if.SB_count), 0);

    // CSR write, then flush racing an issue.
    cyc();
    sb_if.SB_issue_valid  = 1'b1;
    sb_if.SB_issue_csr_we = 1'b1;
    sb_if.SB_issue_csr    = 12'h300;
    cyc();
    idle();
    sb_if.SB_csr_read = 1'b1; sb_if.SB_csr = 12'h300;
    @(negedge clk);
    chk("lit_csr_hit", int'(sb_if.SB_conflict), 1);
    #1 sb_if.SB_csr_read = 1'b0;
    #1 chk("lit_csr_noread", int'(sb_if.SB_conflict), 0);
    issue_rd(7);
    sb_if.SB_flush = 1'b1;
    cyc();
    idle();
    sb_if.SB_rs1_read = 1'b1; sb_if.SB_rs1 = 5'd7;
    sb_if.SB_csr_read = 1'b1; sb_if.SB_csr = 12'h300;
    @(negedge clk);
    chk("lit_flush_issue_count", int'(sb_if.SB_count), 0);
    chk("lit_flush_issue_conflict", int'(sb_if.SB_conflict), 0);

    // Retiring head versus a same-cycle query.
    #1 idle();
    issue_rd(9);
    cyc();
    idle();
    sb_if.SB_rs1_read = 1'b1; sb_if.SB_rs1 = 5'd9;
    @(negedge clk);
    chk("lit_rd9_hit", int'(sb_if.SB_conflict), 1);
    #1 sb_if.SB_retire_valid = 1'b1;
`ifdef YSYX_041461_SB_RETIRE_BYPASS_EN
    #1 chk("lit_rd9_retiring", int'(sb_if.SB_conflict), 0);
`else
    #1 chk("lit_rd9_retiring", int'(sb_if.SB_conflict), 1);
`endif
    cyc();
    sb_if.SB_retire_valid = 1'b0;
    @(negedge clk);
    chk("lit_rd9_gone", int'(sb_if.SB_count), 0);

    // Reset in the middle of operation.
    #1 idle();
    issue_rd(12);
    sb_if.SB_rs1_read = 1'b1; sb_if.SB_rs1 = 5'd12;
    cyc();
    cyc();
    sb_if.SB_issue_valid = 1'b0;
    @(negedge clk);
    chk("lit_pre_rst_count", int'(sb_if.SB_count), 2);
    chk("lit_pre_rst_conflict", int'(sb_if.SB_conflict), 1);
    #1 rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_mid_rst_count", int'(sb_if.SB_count), 0);
    chk("lit_mid_rst_conflict", int'(sb_if.SB_conflict), 0);

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
